// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage hazard controller bus. The ID decoder is the master and the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
   parameter int DEPTH = 3
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic            id_valid;
   logic [4:0]      id_rs;
   logic [4:0]      id_rt;
   logic            id_rs_rd;
   logic            id_rt_rd;
   logic            id_wr;
   logic [4:0]      id_wdst;
   logic            id_is_load;
   logic            id_md;
   logic            id_hilo_rd;
   logic            ex_br_taken;
   logic            stall;
   logic            flush;
   logic            issue;
   logic            md_busy;
   logic [SELW-1:0] fwd_a_sel;
   logic [SELW-1:0] fwd_b_sel;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_rd, id_rt_rd, id_wr, id_wdst,
             id_is_load, id_md, id_hilo_rd, ex_br_taken,
      input  stall, flush, issue, md_busy, fwd_a_sel, fwd_b_sel
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_rd, id_rt_rd, id_wr, id_wdst,
             id_is_load, id_md, id_hilo_rd, ex_br_taken,
      output stall, flush, issue, md_busy, fwd_a_sel, fwd_b_sel
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard/issue controller: in-flight write scoreboard, RAW and MULT/DIV stalls, branch squash.
// Define FORWARD_EN to build with bypass selects and load-use-only stalls.
module pipe_hazard_ctrl #(
   parameter int DEPTH  = 3,
   parameter int MD_LAT = 4
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave hz
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] sb_v;
   logic [4:0]       sb_dst [DEPTH];
   logic [DEPTH-1:0] match_a;
   logic [DEPTH-1:0] match_b;
   logic [5:0]       md_cnt;
   logic [5:0]       md_cnt_nxt;
   logic             md_busy_q;
   logic             raw_hz;
   logic             md_hz;
   logic             flush_w;
   logic             stall_w;
   logic             issue_w;
   logic             push;
   logic [SELW-1:0]  fwd_a;
   logic [SELW-1:0]  fwd_b;
`ifdef FORWARD_EN
   // Only the EX-stage load flag matters: from MEM onward load data is forwardable.
   logic             ld_ex;
`endif

   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         match_a[k] = hz.id_rs_rd && (hz.id_rs != 5'd0) && sb_v[k] && (sb_dst[k] == hz.id_rs);
         match_b[k] = hz.id_rt_rd && (hz.id_rt != 5'd0) && sb_v[k] && (sb_dst[k] == hz.id_rt);
      end
   end

`ifdef FORWARD_EN
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      // Walk oldest to youngest so the youngest producer wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (match_a[k]) fwd_a = SELW'(k + 1);
         if (match_b[k]) fwd_b = SELW'(k + 1);
      end
   end
   assign raw_hz = (match_a[0] || match_b[0]) && ld_ex;
`else
   assign fwd_a  = '0;
   assign fwd_b  = '0;
   assign raw_hz = (|match_a) || (|match_b);
`endif

   assign md_hz   = md_busy_q && (hz.id_md || hz.id_hilo_rd);
   assign flush_w = hz.ex_br_taken;
   assign stall_w = hz.id_valid && !flush_w && (raw_hz || md_hz);
   assign issue_w = hz.id_valid && !stall_w && !flush_w;
   assign push    = issue_w && hz.id_wr && (hz.id_wdst != 5'd0);

   always_comb begin
      md_cnt_nxt = md_cnt;
      if (issue_w && hz.id_md) begin
         md_cnt_nxt = 6'(MD_LAT);
      end else if (md_cnt != 6'd0) begin
         md_cnt_nxt = md_cnt - 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_v      <= '0;
         for (int k = 0; k < DEPTH; k++) sb_dst[k] <= 5'd0;
         md_cnt    <= 6'd0;
         md_busy_q <= 1'b0;
`ifdef FORWARD_EN
         ld_ex     <= 1'b0;
`endif
      end else begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            sb_v[k]   <= sb_v[k-1];
            sb_dst[k] <= sb_dst[k-1];
         end
         sb_v[0]   <= push;
         sb_dst[0] <= push ? hz.id_wdst : 5'd0;
         md_cnt    <= md_cnt_nxt;
         md_busy_q <= (md_cnt_nxt != 6'd0);
`ifdef FORWARD_EN
         ld_ex     <= push && hz.id_is_load;
`endif
      end
   end

   assign hz.stall     = stall_w;
   assign hz.flush     = flush_w;
   assign hz.issue     = issue_w;
   assign hz.md_busy   = md_busy_q;
   assign hz.fwd_a_sel = fwd_a;
   assign hz.fwd_b_sel = fwd_b;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: the driver queues expected outputs, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;
`ifdef FORWARD_EN
   localparam int FW = 1;
`else
   localparam int FW = 0;
`endif

   typedef struct {
      string      tag;
      logic [3:0] ctl;
      int         fa;
      int         fb;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec  = 0;
   int   n_miss = 0;
   exp_t exp_q[$];
   exp_t e;
   logic [3:0] act_ctl;

   pipe_hazard_ctrl_if #(.DEPTH(3)) bus ();

   pipe_hazard_ctrl #(.DEPTH(3), .MD_LAT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (bus)
   );

   always #5 clk = ~clk;

   // ctl order: {stall, flush, issue, md_busy}
   task automatic step(input string tag, input logic rst, input logic vld,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rd,
                       input logic wr, input logic [4:0] wdst, input logic ld,
                       input logic md, input logic hilo, input logic br,
                       input logic [3:0] ctl, input int fa, input int fb);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n           = rst;
      bus.id_valid    = vld;
      bus.id_rs       = rs;
      bus.id_rt       = rt;
      bus.id_rs_rd    = rd[1];
      bus.id_rt_rd    = rd[0];
      bus.id_wr       = wr;
      bus.id_wdst     = wdst;
      bus.id_is_load  = ld;
      bus.id_md       = md;
      bus.id_hilo_rd  = hilo;
      bus.ex_br_taken = br;
      x.tag = tag;
      x.ctl = ctl;
      x.fa  = fa;
      x.fb  = fb;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         act_ctl = {bus.stall, bus.flush, bus.issue, bus.md_busy};
         n_vec++;
         if (act_ctl !== e.ctl || int'(bus.fwd_a_sel) != e.fa || int'(bus.fwd_b_sel) != e.fb) begin
            n_miss++;
            $display("FAIL %s: got stall/flush/issue/busy=%b fa=%0d fb=%0d, want %b fa=%0d fb=%0d",
                     e.tag, act_ctl, bus.fwd_a_sel, bus.fwd_b_sel, e.ctl, e.fa, e.fb);
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      bus.id_valid    = 1'b0;
      bus.id_rs       = 5'd0;
      bus.id_rt       = 5'd0;
      bus.id_rs_rd    = 1'b0;
      bus.id_rt_rd    = 1'b0;
      bus.id_wr       = 1'b0;
      bus.id_wdst     = 5'd0;
      bus.id_is_load  = 1'b0;
      bus.id_md       = 1'b0;
      bus.id_hilo_rd  = 1'b0;
      bus.ex_br_taken = 1'b0;

      // reset held two cycles with a writing MULT in ID; nothing may be captured
      step("rst0",  0,1, 3,3,2'b11, 1,3,1, 1,0,0, 4'b0010, 0,0);
      step("rst1",  0,1, 3,3,2'b11, 1,3,1, 1,0,0, 4'b0010, 0,0);
      step("rel",   1,1, 3,3,2'b11, 0,0,0, 0,1,0, 4'b0010, 0,0);

`ifdef FORWARD_EN
      step("f_prod",  1,1, 1,2,2'b11, 1,3,0, 0,0,0, 4'b0010, 0,0);
      step("f_ex",    1,1, 3,4,2'b11, 1,6,0, 0,0,0, 4'b0010, 1,0);
      step("f_lw",    1,1, 3,0,2'b10, 1,5,1, 0,0,0, 4'b0010, 2,0);
      step("f_luse",  1,1, 3,5,2'b11, 0,0,0, 0,0,0, 4'b1000, 3,1);
      step("f_lfwd",  1,1, 3,5,2'b11, 0,0,0, 0,0,0, 4'b0010, 0,2);
      step("f_wb",    1,1, 5,0,2'b10, 1,0,0, 0,0,0, 4'b0010, 3,0);
      step("f_r0",    1,1, 0,0,2'b11, 0,0,0, 0,0,0, 4'b0010, 0,0);
      step("y_w1",    1,1, 0,0,2'b00, 1,7,0, 0,0,0, 4'b0010, 0,0);
      step("y_bub",   1,0, 0,0,2'b00, 0,0,0, 0,0,0, 4'b0000, 0,0);
      step("y_w2",    1,1, 0,0,2'b00, 1,7,0, 0,0,0, 4'b0010, 0,0);
      step("y_young", 1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b0010, 1,1);
      step("y_s2",    1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b0010, 2,2);
      step("y_s3",    1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b0010, 3,3);
      step("y_gone",  1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b0010, 0,0);
`else
      step("r_prod",  1,1, 1,2,2'b11, 1,3,0, 0,0,0, 4'b0010, 0,0);
      step("r_st1",   1,1, 3,4,2'b11, 1,6,0, 0,0,0, 4'b1000, 0,0);
      step("r_st2",   1,1, 3,4,2'b11, 1,6,0, 0,0,0, 4'b1000, 0,0);
      step("r_st3",   1,1, 3,4,2'b11, 1,6,0, 0,0,0, 4'b1000, 0,0);
      step("r_iss",   1,1, 3,4,2'b11, 1,6,0, 0,0,0, 4'b0010, 0,0);
      step("r_w0",    1,1, 0,0,2'b00, 1,0,0, 0,0,0, 4'b0010, 0,0);
      step("r_r0",    1,1, 0,0,2'b11, 0,0,0, 0,0,0, 4'b0010, 0,0);
      step("r_nord",  1,1, 6,0,2'b01, 0,0,0, 0,0,0, 4'b0010, 0,0);
      step("y_w1",    1,1, 0,0,2'b00, 1,7,0, 0,0,0, 4'b0010, 0,0);
      step("y_bub",   1,0, 0,0,2'b00, 0,0,0, 0,0,0, 4'b0000, 0,0);
      step("y_w2",    1,1, 0,0,2'b00, 1,7,0, 0,0,0, 4'b0010, 0,0);
      step("y_st1",   1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b1000, 0,0);
      step("y_st2",   1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b1000, 0,0);
      step("y_st3",   1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b1000, 0,0);
      step("y_iss",   1,1, 7,7,2'b11, 0,0,0, 0,0,0, 4'b0010, 0,0);
`endif

      // MULT then MFLO: four MD stall cycles, then back-to-back MULT after expiry
      step("m_mult",  1,1, 1,2,2'b11, 0,0,0, 1,0,0, 4'b0010, 0,0);
      step("m_st1",   1,1, 0,0,2'b00, 1,8,0, 0,1,0, 4'b1001, 0,0);
      step("m_st2",   1,1, 0,0,2'b00, 1,8,0, 0,1,0, 4'b1001, 0,0);
      step("m_st3",   1,1, 0,0,2'b00, 1,8,0, 0,1,0, 4'b1001, 0,0);
      step("m_st4",   1,1, 0,0,2'b00, 1,8,0, 0,1,0, 4'b1001, 0,0);
      step("m_mflo",  1,1, 0,0,2'b00, 1,8,0, 0,1,0, 4'b0010, 0,0);
      step("m_mult2", 1,1, 0,0,2'b00, 0,0,0, 1,0,0, 4'b0010, 0,0);
      step("m_busy",  1,1, 8,0,2'b10, 0,0,0, 1,0,0, 4'b1001, 2*FW,0);
      // branch squash of a stalled consumer: no stall, no issue, no counter reload
      step("b_flush", 1,1, 8,0,2'b10, 1,9,0, 1,0,1, 4'b0101, 3*FW,0);
      step("b_bub",   1,1, 9,0,2'b10, 0,0,0, 0,0,0, 4'b0011, 0,0);
      step("b_cnt1",  1,0, 0,0,2'b00, 0,0,0, 0,0,0, 4'b0001, 0,0);
      step("b_cnt0",  1,0, 0,0,2'b00, 0,0,0, 0,0,0, 4'b0000, 0,0);
      // reset while the MD counter holds 2 and ID is stalled
      step("x_mult",  1,1, 0,0,2'b00, 0,0,0, 1,0,0, 4'b0010, 0,0);
      step("x_c4",    1,0, 0,0,2'b00, 0,0,0, 0,0,0, 4'b0001, 0,0);
      step("x_c3",    1,0, 0,0,2'b00, 0,0,0, 0,0,0, 4'b0001, 0,0);
      step("x_rst",   0,1, 0,0,2'b00, 0,0,0, 0,1,0, 4'b1001, 0,0);
      step("x_after", 1,1, 0,0,2'b00, 0,0,0, 0,1,0, 4'b0010, 0,0);
      step("x_brnv",  1,0, 0,0,2'b00, 0,0,0, 0,0,1, 4'b0100, 0,0);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Decode-stage hazard and issue controller for the static MIPS pipeline; it sits beside the combinational control unit in ID. It keeps a scoreboard of in-flight register writes across a parametrised number of stages. It stalls ID on RAW hazards and on busy multi-cycle MULT/DIV, and squashes ID on a taken branch resolved in EX. With forwarding compiled in, it also generates bypass selects.

Parameters:
DEPTH, 3, stages after ID whose results are not yet readable from the regfile (EX, MEM, WB); legal 1..8
MD_LAT, 4, busy cycles of the MULT/DIV unit after issue; legal 1..63
SELW, $clog2(DEPTH+1), width of forwarding selects (derived, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  5  rs field
id_rt  in  5  rt field
id_rs_rd  in  1  instruction reads rs (rf_rena1)
id_rt_rd  in  1  instruction reads rt (rf_rena2)
id_wr  in  1  instruction writes regfile (rf_wena)
id_wdst  in  5  destination register
id_is_load  in  1  instruction is LW
id_md  in  1  instruction starts MULT/MULTU/DIV/DIVU
id_hilo_rd  in  1  instruction is MFHI/MFLO
ex_br_taken  in  1  branch/jump in EX redirects PC this cycle
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush  out  1  squash IF/ID contents
issue  out  1  ID instruction advances into EX this cycle
md_busy  out  1  MULT/DIV counter non-zero
fwd_a_sel  out  SELW  rs bypass source: 0 = regfile, k = stage k (1 = EX)
fwd_b_sel  out  SELW  rt bypass source, same encoding

Behaviour:
- Scoreboard: DEPTH entries {v, dst[4:0], ld}; entry 0 = EX, entry DEPTH-1 = last unreadable stage.
- Each clock, entries shift 0 to DEPTH-1; the oldest entry drops out. Entry 0 loads {1, id_wdst, id_is_load} when issue & id_wr & id_wdst != 0; otherwise it loads a bubble {0, 0, 0}.
- Match on rs for entry k: id_rs_rd & id_rs != 0 & v[k] & dst[k] == id_rs. The match on rt is the same using id_rt.
- raw_hz without FORWARD_EN: any rs/rt match in any entry.
- md_hz: md_busy & (id_md | id_hilo_rd).
- flush = ex_br_taken (combinational).
- stall = id_valid & ~flush & (raw_hz | md_hz). Flush has priority; a squashed instruction never stalls.
- issue = id_valid & ~stall & ~flush.
- MD counter: 6-bit; loads MD_LAT when issue & id_md; otherwise decrements while non-zero and saturates at 0.
- md_busy = (counter != 0). id_md issuing when the counter is 0 is legal (back-to-back after expiry).
- Stall holds no scoreboard entry; shifting continues, so hazards clear naturally. Stall duration ≤ DEPTH cycles for RAW and ≤ MD_LAT for MD.
- Register $0 never creates a hazard or forward.
- Reset (rst_n low at edge): all v = 0, dst = 0, ld = 0, counter = 0. Outputs are then stall = 0, flush = ex_br_taken, md_busy = 0, fwd selects = 0. Reset mid-stall or mid-MD discards all state; there is no residual stall on the next cycle.
- Outputs stall, flush, issue and fwd_*_sel are combinational from inputs and registered state, valid the same cycle. md_busy is registered.

Optional Feature:
FORWARD_EN:
- Defined: raw_hz = rs/rt match on entry 0 with ld[0] = 1 (load-use only; one bubble).
- Defined: fwd_a_sel / fwd_b_sel = index+1 of the youngest (lowest k) matching entry, else 0. Forwarding is computed even when stall or flush is asserted.
- Undefined: full-stall raw_hz as above; fwd_a_sel = fwd_b_sel = 0 constantly.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with id_valid = 1 → stall = 0, md_busy = 0, fwd = 0. Release: first cycle has an empty scoreboard.
- RAW, no FORWARD_EN, DEPTH = 3: ADDU $3←…, then ADDU reading $3 → stall = 1 for exactly 3 cycles, issue on the 4th. Writing $0 then reading $0 → no stall.
- Load-use with FORWARD_EN: LW $5, then ADD reading $5 as rt → 1 stall cycle, then issue with fwd_b_sel = 2. A non-load producer followed immediately by a consumer → fwd_a_sel = 1, no stall.
- MULT/DIV, MD_LAT = 4: MULT issues, then MFLO → stall 4 cycles, md_busy high 4 cycles. A second MULT issues the cycle after md_busy falls.
- Branch squash: ex_br_taken = 1 while ID holds a stalled RAW consumer → flush = 1, stall = 0, issue = 0, entry 0 gets a bubble, md counter unchanged.
- Youngest-wins and reset mid-operation: $7 written at stages 1 and 3 → fwd_a_sel = 1. Assert rst_n = 0 during an MD count of 2 → md_busy = 0 next cycle.
